// File: rtl/pmu_event_conditioner.sv
// PMU event conditioner: per-output source crossbar, level/edge qualification
// and prescaling, producing registered single-cycle pulses for the PMU.
module pmu_event_conditioner #(
    parameter int unsigned N_SRC   = 32,
    parameter int unsigned N_OUT   = 9,
    parameter int unsigned PRESC_W = 8,
    localparam int unsigned IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               enable_i,
    input  logic [N_SRC-1:0]   events_raw_i,
    input  logic               cfg_we_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [N_OUT-1:0]   events_o
);

    localparam int unsigned CFG_W = 7 + PRESC_W;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_LEVEL = 2'b01,
        MODE_RISE  = 2'b10,
        MODE_FALL  = 2'b11
    } mode_e;

    logic [N_SRC-1:0]   raw_q;
    logic [N_SRC-1:0]   raw_qq;
    logic [31:0]        cur_ext;
    logic [31:0]        prev_ext;
    logic [CFG_W-1:0]   cfg_q [N_OUT];
    logic [PRESC_W-1:0] cnt_q [N_OUT];
    logic [N_OUT-1:0]   qual;
    logic [N_OUT-1:0]   wr_sel;
    logic [31:0]        rd_word;

    // Sources above N_SRC read as constant 0 in both pipeline stages, so every
    // mode qualifies them to 0 without an explicit range check.
    always_comb begin
        cur_ext              = '0;
        prev_ext             = '0;
        cur_ext[N_SRC-1:0]   = raw_q;
        prev_ext[N_SRC-1:0]  = raw_qq;
    end

    always_comb begin
        qual = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            case (mode_e'(cfg_q[i][6:5]))
                MODE_LEVEL: qual[i] = cur_ext[cfg_q[i][4:0]];
                MODE_RISE:  qual[i] = cur_ext[cfg_q[i][4:0]] & ~prev_ext[cfg_q[i][4:0]];
                MODE_FALL:  qual[i] = ~cur_ext[cfg_q[i][4:0]] & prev_ext[cfg_q[i][4:0]];
                default:    qual[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            wr_sel[i] = cfg_we_i && (cfg_idx_i == IDX_W'(i));
            if (cfg_idx_i == IDX_W'(i)) begin
                rd_word = 32'(cfg_q[i]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            raw_q       <= '0;
            raw_qq      <= '0;
            events_o    <= '0;
            cfg_rdata_o <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                cfg_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            raw_q       <= events_raw_i;
            raw_qq      <= raw_q;
            cfg_rdata_o <= rd_word;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (wr_sel[i]) begin
                    cfg_q[i]    <= cfg_wdata_i[CFG_W-1:0];
                    cnt_q[i]    <= '0;
                    events_o[i] <= 1'b0;
                end else if (enable_i && qual[i]) begin
                    if (cnt_q[i] == cfg_q[i][CFG_W-1:7]) begin
                        cnt_q[i]    <= '0;
                        events_o[i] <= 1'b1;
                    end else begin
                        cnt_q[i]    <= cnt_q[i] + PRESC_W'(1);
                        events_o[i] <= 1'b0;
                    end
                end else begin
                    events_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pmu_event_conditioner.sv
// Self-checking bench for pmu_event_conditioner: directed scenarios plus a
// randomized run compared against an event-counting reference model.
module tb_pmu_event_conditioner;

    localparam int N_SRC = 32;
    localparam int N_OUT = 9;
    localparam int IDX_W = 4;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             enable_i;
    logic [N_SRC-1:0] events_raw_i;
    logic             cfg_we_i;
    logic [IDX_W-1:0] cfg_idx_i;
    logic [31:0]      cfg_wdata_i;
    logic [31:0]      cfg_rdata_o;
    logic [N_OUT-1:0] events_o;

    int checks = 0;
    int errors = 0;

    pmu_event_conditioner #(.N_SRC(32), .N_OUT(9), .PRESC_W(8)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .enable_i     (enable_i),
        .events_raw_i (events_raw_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .events_o     (events_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: remembers the last two sampled raw words, the stored
    // config words and how many qualified events each output has seen since
    // its last config write; a pulse is due on every (P+1)-th event.
    logic [31:0]      m_raw1, m_raw2;
    logic [31:0]      m_cfg [N_OUT];
    int               m_nq  [N_OUT];
    logic [N_OUT-1:0] exp_ev;
    logic [31:0]      exp_rd;

    function automatic bit model_q(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
        int s;
        int m;
        s = int'(w & 32'h1F);
        m = int'((w >> 5) & 32'h3);
        case (m)
            1:       return r1[s];
            2:       return r1[s] & ~r2[s];
            3:       return ~r1[s] & r2[s];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_p(input logic [31:0] w);
        return int'((w >> 7) & 32'hFF);
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_raw1 <= '0;
            m_raw2 <= '0;
            exp_ev <= '0;
            exp_rd <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                m_cfg[i] <= '0;
                m_nq[i]  <= 0;
            end
        end else begin
            m_raw1 <= events_raw_i;
            m_raw2 <= m_raw1;
            exp_rd <= (int'(cfg_idx_i) < N_OUT) ? m_cfg[cfg_idx_i] : 32'h0;
            for (int i = 0; i < N_OUT; i++) begin
                if (cfg_we_i && int'(cfg_idx_i) == i) begin
                    m_cfg[i]  <= cfg_wdata_i & 32'h7FFF;
                    m_nq[i]   <= 0;
                    exp_ev[i] <= 1'b0;
                end else if (enable_i && model_q(m_cfg[i], m_raw1, m_raw2)) begin
                    m_nq[i]   <= m_nq[i] + 1;
                    exp_ev[i] <= ((m_nq[i] + 1) % (model_p(m_cfg[i]) + 1)) == 0;
                end else begin
                    exp_ev[i] <= 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 4'(idx);
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic test_reset;
        rstn_i       = 1'b0;
        enable_i     = 1'b1;
        events_raw_i = '1;
        cfg_we_i     = 1'b0;
        cfg_idx_i    = '0;
        cfg_wdata_i  = '0;
        repeat (3) tick();
        checks++;
        if (events_o !== 9'h0) begin
            errors++;
            $display("FAIL reset_events got %h want 0", events_o);
        end
        checks++;
        if (cfg_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", cfg_rdata_o);
        end
        rstn_i = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            cfg_idx_i = 4'(k);
            tick();
            checks++;
            if (cfg_rdata_o !== 32'h0 || events_o !== 9'h0) begin
                errors++;
                $display("FAIL reset_read idx=%0d rdata %h events %h want 0/0", k, cfg_rdata_o, events_o);
            end
        end
        events_raw_i = '0;
    endtask

    task automatic test_rising;
        cfg_write(0, 32'h43);
        cfg_idx_i = 4'd0;
        tick();
        tick();
        events_raw_i[3] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (events_o !== ((e == 2) ? 9'h001 : 9'h000)) begin
                errors++;
                $display("FAIL rise_pulse e=%0d got %h want %h", e, events_o, (e == 2) ? 9'h001 : 9'h000);
            end
        end
    endtask

    task automatic test_level_presc;
        cfg_write(1, 32'h1A5);
        events_raw_i[5] = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == 12) events_raw_i[5] = 1'b0;
            checks++;
            if (events_o !== ((e == 5 || e == 9 || e == 13) ? 9'h002 : 9'h000)) begin
                errors++;
                $display("FAIL level_presc e=%0d got %h want %h", e, events_o,
                         (e == 5 || e == 9 || e == 13) ? 9'h002 : 9'h000);
            end
        end
    endtask

    task automatic test_falling;
        int pulses;
        pulses = 0;
        cfg_write(2, 32'h7F);
        tick();
        events_raw_i[31] = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            events_raw_i[31] = (e < 8) ? ~events_raw_i[31] : 1'b0;
            if (events_o[2]) pulses++;
            checks++;
            if (events_o !== ((e % 2 == 1 && e >= 3 && e <= 9) ? 9'h004 : 9'h000)) begin
                errors++;
                $display("FAIL falling e=%0d got %h want %h", e, events_o,
                         (e % 2 == 1 && e >= 3 && e <= 9) ? 9'h004 : 9'h000);
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL falling_count got %0d want 4", pulses);
        end
    endtask

    task automatic test_rewrite;
        events_raw_i[5] = 1'b1;
        tick();
        tick();
        events_raw_i[5] = 1'b0;
        repeat (3) tick();
        cfg_write(1, 32'hFFFF_81A6);
        checks++;
        if (cfg_rdata_o !== 32'h1A5) begin
            errors++;
            $display("FAIL rewrite_old_rd got %h want 000001a5", cfg_rdata_o);
        end
        tick();
        checks++;
        if (cfg_rdata_o !== 32'h1A6) begin
            errors++;
            $display("FAIL rewrite_new_rd got %h want 000001a6", cfg_rdata_o);
        end
        events_raw_i[6] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 4) events_raw_i[6] = 1'b0;
            checks++;
            if (events_o !== ((e == 5) ? 9'h002 : 9'h000)) begin
                errors++;
                $display("FAIL rewrite_restart e=%0d got %h want %h", e, events_o, (e == 5) ? 9'h002 : 9'h000);
            end
        end
    endtask

    task automatic test_enable;
        logic [31:0] want_rd [N_OUT];
        events_raw_i[6] = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3) enable_i = 1'b0;
            if (e == 8) enable_i = 1'b1;
            if (e == 10) events_raw_i[6] = 1'b0;
            checks++;
            if (events_o !== ((e == 10) ? 9'h002 : 9'h000)) begin
                errors++;
                $display("FAIL enable_hold e=%0d got %h want %h", e, events_o, (e == 10) ? 9'h002 : 9'h000);
            end
        end
        tick();
        cfg_write(12, 32'hFFFF_FFFF);
        checks++;
        if (cfg_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL bad_idx_read got %h want 0", cfg_rdata_o);
        end
        for (int k = 0; k < N_OUT; k++) want_rd[k] = 32'h0;
        want_rd[0] = 32'h43;
        want_rd[1] = 32'h1A6;
        want_rd[2] = 32'h7F;
        for (int k = 0; k < N_OUT; k++) begin
            cfg_idx_i = 4'(k);
            tick();
            checks++;
            if (cfg_rdata_o !== want_rd[k]) begin
                errors++;
                $display("FAIL cfg_intact idx=%0d got %h want %h", k, cfg_rdata_o, want_rd[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        cfg_idx_i       = 4'd1;
        events_raw_i[6] = 1'b1;
        repeat (3) tick();
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (events_o !== 9'h0 || cfg_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset events %h rdata %h want 0/0", events_o, cfg_rdata_o);
        end
        tick();
        rstn_i       = 1'b1;
        events_raw_i = '0;
        tick();
        tick();
        checks++;
        if (cfg_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_cfg got %h want 0", cfg_rdata_o);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            cfg_we_i     = (c < N_OUT) || ($urandom % 10 == 0);
            cfg_idx_i    = (c < N_OUT) ? 4'(c) : 4'($urandom_range(0, 15));
            cfg_wdata_i  = $urandom & ~32'h0000_7E00;
            enable_i     = ($urandom % 8) != 0;
            events_raw_i = $urandom;
            tick();
            checks++;
            if (events_o !== exp_ev) begin
                errors++;
                $display("FAIL rand_events c=%0d got %h want %h", c, events_o, exp_ev);
            end
            checks++;
            if (cfg_rdata_o !== exp_rd) begin
                errors++;
                $display("FAIL rand_rdata c=%0d got %h want %h", c, cfg_rdata_o, exp_rd);
            end
        end
        cfg_we_i = 1'b0;
        enable_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rising();
        test_level_presc();
        test_falling();
        test_rewrite();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
